// File: rtl/pc_gen_pkg.sv
// Shared definitions for the IF-stage fetch-address generator: bus widths,
// control-level constants, reset/exception vectors and the PC FSM encoding.
package pc_gen_pkg;

    localparam int ADDR_W_DEF = 32;
    typedef logic [ADDR_W_DEF-1:0] inst_addr_t;

    localparam logic RstEnable   = 1'b1;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic StallEnable = 1'b1;

    // Default reset vector and the exception entry points that feed flush_target.
    localparam inst_addr_t RESET_VEC_DEF    = 32'h0000_0000;
    localparam inst_addr_t EXC_VEC_GENERAL  = 32'h8000_0180;
    localparam inst_addr_t EXC_VEC_BOOT_GEN = 32'hBFC0_0380;
    localparam inst_addr_t EXC_VEC_RESET    = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } pc_state_e;

    // Next FSM state once out of reset; flush beats stall, stall+branch parks a target.
    function automatic pc_state_e pc_state_step(
        input pc_state_e state,
        input logic      stall,
        input logic      br_valid,
        input logic      flush
    );
        pc_state_e nxt;
        nxt = state;
        case (state)
            ST_OFF:  nxt = ST_RUN;
            ST_RUN:  if (!flush && stall == StallEnable && br_valid) nxt = ST_HOLD;
            ST_HOLD: if (flush || stall != StallEnable) nxt = ST_RUN;
            default: nxt = ST_OFF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pc_gen_redirect_latch.sv
// Pending-redirect latch: remembers a branch target resolved while the
// pipeline is stalled until the PC mux can consume it.
module pc_redirect_latch
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic              clear,
    input  logic [ADDR_W-1:0] target_in,
    output logic              pending,
    output logic [ADDR_W-1:0] target
);

    logic              pending_reg;
    logic              pending_next;
    logic [ADDR_W-1:0] target_reg;
    logic [ADDR_W-1:0] target_next;

    // A second set while pending simply overwrites the target with the newer branch.
    always_comb begin
        pending_next = pending_reg;
        target_next  = target_reg;
        if (clear) begin
            pending_next = 1'b0;
        end else if (set) begin
            pending_next = 1'b1;
            target_next  = target_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pending_reg <= 1'b0;
            target_reg  <= '0;
        end else begin
            pending_reg <= pending_next;
            target_reg  <= target_next;
        end
    end

    assign pending = pending_reg;
    assign target  = target_reg;

endmodule

// File: rtl/pc_gen.sv
// IF-stage fetch-address generator: sequential increment, stall hold,
// ID branch/jump redirect with pending latch, and exception/ERET flush.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
    parameter int              INC        = 4,
    parameter int              ALIGN_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_target,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              redirect_pending,
    output logic              pc_misaligned
);

    pc_state_e         state_reg;
    pc_state_e         state_next;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic              lat_set;
    logic              lat_clear;
    logic              lat_pending;
    logic [ADDR_W-1:0] lat_target;

    pc_redirect_latch #(
        .ADDR_W (ADDR_W)
    ) u_latch (
        .clk       (clk),
        .rst       (rst),
        .set       (lat_set),
        .clear     (lat_clear),
        .target_in (br_target),
        .pending   (lat_pending),
        .target    (lat_target)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_reg <= ST_OFF;
            pc_reg    <= RESET_VEC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    // Redirect priority: flush > stall (park branch) > live branch > parked branch > +INC.
    // In OFF everything is ignored so the first fetch is always RESET_VEC.
    always_comb begin
        state_next = pc_state_step(state_reg, stall, br_valid, flush);
        pc_next    = pc_reg;
        lat_set    = 1'b0;
        lat_clear  = 1'b0;
        if (state_reg != ST_OFF) begin
            if (flush) begin
                pc_next   = flush_target;
                lat_clear = 1'b1;
            end else if (stall == StallEnable) begin
                lat_set = br_valid;
            end else if (br_valid) begin
                pc_next   = br_target;
                lat_clear = 1'b1;
            end else if (state_reg == ST_HOLD) begin
                pc_next   = lat_target;
                lat_clear = 1'b1;
            end else begin
                pc_next = pc_reg + ADDR_W'(INC);
            end
        end
    end

    assign pc               = pc_reg;
    assign ce               = (state_reg != ST_OFF) ? ChipEnable : ChipDisable;
    assign redirect_pending = lat_pending;

    generate
        if (ALIGN_BITS > 0) begin : g_align
            assign pc_misaligned = ce & (|pc_reg[ALIGN_BITS-1:0]);
        end else begin : g_no_align
            assign pc_misaligned = 1'b0;
        end
    endgenerate

endmodule
